// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light controller: state encoding and lamp patterns.
package traffic_pkg;

  typedef enum logic [1:0] {RED, GREEN, YELLOW, FLASH} state_t;

  // Lamp vectors are ordered {red, yellow, green}.
  localparam logic [2:0] LAMP_OFF    = 3'b000;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  function automatic logic [2:0] lamp_of(state_t s);
    logic [2:0] lamp;
    case (s)
      RED:     lamp = LAMP_RED;
      GREEN:   lamp = LAMP_GREEN;
      YELLOW:  lamp = LAMP_YELLOW;
      default: lamp = LAMP_OFF;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: counts 0..CLK_PER_SEC-1 and pulses tick on the last count.
module sec_tick #(
  parameter int unsigned CLK_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = $clog2(CLK_PER_SEC);
  localparam logic [W-1:0] LAST = W'(CLK_PER_SEC - 1);

  logic [W-1:0] pre_q, pre_d;

  assign tick = (pre_q == LAST);

  always_comb begin
    pre_d = pre_q + W'(1);
    if (clr || tick) pre_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Single-head traffic light: RED -> GREEN -> YELLOW cycle with seconds countdown,
// pedestrian shortening of green, and a night flash mode with the display blanked.
//   state  | meaning
//   RED    | red lamp, counting down RED_SEC
//   GREEN  | green lamp, counting down GREEN_SEC (or PED_SEC after a request)
//   YELLOW | yellow lamp, counting down YELLOW_SEC
//   FLASH  | night mode, yellow toggles each second, display blanked
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 50_000_000,
  parameter int unsigned RED_SEC     = 9,
  parameter int unsigned GREEN_SEC   = 9,
  parameter int unsigned YELLOW_SEC  = 3,
  parameter int unsigned PED_SEC     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  input  logic       night,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic [7:0] dec_num,
  output logic       seg_en_n
);

  if (CLK_PER_SEC < 2 ||
      RED_SEC    < 1 || RED_SEC    > 9 ||
      GREEN_SEC  < 1 || GREEN_SEC  > 9 ||
      YELLOW_SEC < 1 || YELLOW_SEC > 9 ||
      PED_SEC    < 1 || PED_SEC    > GREEN_SEC) begin : g_bad_param
    $error("traffic_light_ctrl: timing parameter out of range");
  end

  localparam logic [3:0] RED_DUR    = 4'(RED_SEC);
  localparam logic [3:0] GREEN_DUR  = 4'(GREEN_SEC);
  localparam logic [3:0] YELLOW_DUR = 4'(YELLOW_SEC);
  localparam logic [3:0] PED_DUR    = 4'(PED_SEC);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ped_pend_q, ped_pend_d;
  logic [2:0] lamp_q, lamp_d;
  logic       seg_en_n_q, seg_en_n_d;
  logic       tick, pre_clr, ped_now;

  sec_tick #(.CLK_PER_SEC(CLK_PER_SEC)) u_sec_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pre_clr),
    .tick  (tick)
  );

  // A request in the current cycle acts immediately, not one cycle late.
  assign ped_now = ped_pend_q | ped_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RED;
      cnt_q      <= RED_DUR;
      ped_pend_q <= 1'b0;
      lamp_q     <= LAMP_RED;
      seg_en_n_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ped_pend_q <= ped_pend_d;
      lamp_q     <= lamp_d;
      seg_en_n_q <= seg_en_n_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ped_pend_d = ped_now;
    pre_clr    = 1'b0;
    if (night) begin
      state_d = FLASH;
      cnt_d   = '0;
      if (state_q != FLASH) begin
        pre_clr    = 1'b1;
        ped_pend_d = 1'b0;
      end
    end else if (state_q == FLASH) begin
      state_d = RED;
      cnt_d   = RED_DUR;
      pre_clr = 1'b1;
    end else if (state_q == GREEN && ped_now && cnt_q > PED_DUR) begin
      // Shortening load swallows a coincident tick; prescaler keeps running.
      cnt_d = PED_DUR;
    end else if (tick) begin
      if (cnt_q == 4'd1) begin
        case (state_q)
          RED: begin
            state_d = GREEN;
            cnt_d   = GREEN_DUR;
          end
          GREEN: begin
            state_d    = YELLOW;
            cnt_d      = YELLOW_DUR;
            ped_pend_d = 1'b0;
          end
          default: begin
            state_d = RED;
            cnt_d   = RED_DUR;
          end
        endcase
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    lamp_d     = lamp_of(state_d);
    seg_en_n_d = 1'b0;
    if (state_d == FLASH) begin
      seg_en_n_d = 1'b1;
      if (state_q != FLASH) lamp_d = LAMP_YELLOW;
      else if (tick)        lamp_d = lamp_q ^ LAMP_YELLOW;
      else                  lamp_d = lamp_q;
    end
  end

  assign red      = lamp_q[2];
  assign yellow   = lamp_q[1];
  assign green    = lamp_q[0];
  assign dec_num  = {4'b0000, cnt_q};
  assign seg_en_n = seg_en_n_q;

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Sequential controller for a single traffic-light head. It cycles RED → GREEN → YELLOW → RED on a seconds time base and drives the three lamp outputs. It also drives the remaining-seconds countdown digit and the active-low display enable, which connect directly to the seven-segment decoder (`seg_display`). It supports a pedestrian request that shortens green, and a night mode that flashes yellow with the display blanked.

## Interface
Parameters:
- `CLK_PER_SEC`, default 50_000_000: clock cycles per one-second tick; legal value ≥ 2.
- `RED_SEC`, default 9: red duration in seconds; legal range 1..9.
- `GREEN_SEC`, default 9: green duration in seconds; legal range 1..9.
- `YELLOW_SEC`, default 3: yellow duration in seconds; legal range 1..9.
- `PED_SEC`, default 3: remaining green seconds after a pedestrian request; legal range 1..GREEN_SEC.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1 bit: system clock; all state changes on the rising edge.
- `rst_n`, input, 1 bit: asynchronous active-low reset.
- `ped_req`, input, 1 bit: pedestrian request level, already synchronous to `clk`.
- `night`, input, 1 bit: night/flash mode select, already synchronous to `clk`.
- `red`, output, 1 bit: red lamp, registered.
- `yellow`, output, 1 bit: yellow lamp, registered.
- `green`, output, 1 bit: green lamp, registered.
- `dec_num`, output, 8 bits: countdown digit for the decoder, registered; bits [7:4] are always 0.
- `seg_en_n`, output, 1 bit: display enable for the decoder `en`; 0 = display shown, 1 = blanked; registered.

## Operation
- States: RED, GREEN, YELLOW, FLASH.
- Exactly one of `red`/`green`/`yellow` is 1 in RED, GREEN and YELLOW.
- Countdown register `cnt` (4 bits):
  - On entry to a state it loads that state's duration.
  - On each tick it decrements.
  - On a tick with `cnt == 1` the FSM transitions and `cnt` loads the next state's duration.
  - The displayed values are therefore DUR, DUR−1, …, 1. The value 0 is never shown in the normal cycle.
- `dec_num = {4'b0, cnt}`. `seg_en_n = 0` in RED, GREEN and YELLOW.
- Pedestrian request:
  - `ped_req == 1` in any cycle sets the `ped_pend` flag.
  - `ped_pend` clears on entry to YELLOW or FLASH.
  - In GREEN with `ped_pend == 1` and `cnt > PED_SEC`: `cnt` loads `PED_SEC` on the next edge. The prescaler is not reset.
  - If a tick coincides with that load, the load wins and the tick is consumed.
  - With `cnt ≤ PED_SEC`, the request has no effect on timing.
- Night mode:
  - `night == 1` in any state → FLASH on the next edge.
  - On that edge the prescaler resets to 0, `yellow = 1`, `red = green = 0`, `seg_en_n = 1`, `dec_num = 0`.
  - While in FLASH, `yellow` toggles on every tick.
  - `night == 0` in FLASH → RED on the next edge, with `cnt = RED_SEC`, prescaler = 0 and `seg_en_n = 0`.
- Reset values: state RED, `cnt = RED_SEC`, prescaler 0, `ped_pend = 0`, `red = 1`, `yellow = green = 0`, `dec_num = RED_SEC`, `seg_en_n = 0`.

## Timing
- Prescaler counts 0..`CLK_PER_SEC`−1.
  - `tick` is a 1-cycle pulse while the prescaler equals `CLK_PER_SEC`−1.
  - The prescaler wraps to 0 on the same edge.
- All outputs are registered. Tick in cycle N → new `cnt`/lamps are visible after edge N.
- First tick after reset occurs `CLK_PER_SEC` cycles after `rst_n` deasserts.
- Each displayed digit therefore persists exactly `CLK_PER_SEC` cycles, except after a pedestrian load.
- Full cycle length: (RED_SEC + GREEN_SEC + YELLOW_SEC) × `CLK_PER_SEC` cycles.
- `night` takes priority over `ped_req` and tick in the same cycle.
- `rst_n` asserted mid-state: all registers clear to reset values immediately, without waiting for a clock edge.
- Outputs are never X after reset. No combinational path exists from inputs to outputs.

## Structure
- Shared package `traffic_pkg`: state enum (RED, GREEN, YELLOW, FLASH) and the lamp-vector constants.
- Sub-module `sec_tick`: parameterised prescaler with inputs `clk`, `rst_n`, `clr` and output `tick`. `clr` forces the count to 0.
- Top-level elaboration check: every duration parameter is in range and `PED_SEC ≤ GREEN_SEC`; an out-of-range value fails elaboration.

## Test plan
All scenarios use `CLK_PER_SEC = 4`, `RED_SEC = 5`, `GREEN_SEC = 6`, `YELLOW_SEC = 2`, `PED_SEC = 3`.
1. Reset release, run 52 cycles → outputs follow this sequence, each digit held 4 cycles, then red again with `dec_num = 5`:
   - red with `dec_num` 5..1;
   - green with `dec_num` 6..1;
   - yellow with `dec_num` 2..1.
2. Pulse `ped_req` for 1 cycle while green and `dec_num = 6` → next edge `dec_num = 3`; yellow follows 12 cycles later.
3. `ped_req` while green and `dec_num = 2` → no change; the request clears on entry to yellow and does not affect the next green.
4. Assert `night` during green → next edge gives `yellow = 1`, `seg_en_n = 1`, `dec_num = 0`; `yellow` then toggles every 4 cycles. Deassert → red, `dec_num = 5`, 4 cycles per digit.
5. Assert `rst_n = 0` mid-yellow, between clock edges → outputs immediately show red, `dec_num = 5`, `seg_en_n = 0`.
6. `ped_req` coincides with a tick at green `dec_num = 5` → `dec_num` becomes 3, not 4.
